// File: rtl/store_lane_buffer.sv
// Store path buffer: byte-lane steering, misalignment detection and an in-order
// DEPTH-entry FIFO drained over valid/ready. Optional macro STORE_MERGE_EN coalesces same-word stores.
module store_lane_buffer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    st_valid,
    input  logic [ADDR_W-1:0]       st_addr,
    input  logic [DATA_W-1:0]       st_data,
    input  logic [1:0]              st_size,
    input  logic                    Req,
    output logic                    st_ready,
    output logic                    st_misalign,
    output logic                    mem_valid,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    output logic [DATA_W/8-1:0]     mem_byteen,
    input  logic                    mem_ready,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int B  = DATA_W / 8;
    localparam int L  = $clog2(B);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [B-1:0]      be_q   [DEPTH];
    logic [PW-1:0]     head_q;
    logic [PW-1:0]     tail_q;
    logic [CW-1:0]     count_q;
    logic              misalign_q;

    logic [L-1:0]      off_s;
    logic [L-1:0]      low_mask_s;
    logic [ADDR_W-1:0] aligned_addr_s;
    logic [DATA_W-1:0] data_mask_s;
    logic [DATA_W-1:0] wdata_s;
    logic [B-1:0]      be_mask_s;
    logic [B-1:0]      byteen_s;
    logic              misal_s;
    logic              mem_valid_s;
    logic              deq_s;
    logic              take_s;
    logic              merge_s;
    logic              alloc_s;

    // Lane steering and misalignment classification of the incoming store.
    always_comb begin
        off_s          = st_addr[L-1:0];
        low_mask_s     = ~({L{1'b1}} << st_size);
        aligned_addr_s = {st_addr[ADDR_W-1:L], {L{1'b0}}};
        data_mask_s    = ~({DATA_W{1'b1}} << (32'd8 << st_size));
        be_mask_s      = ~({B{1'b1}} << (32'd1 << st_size));
        wdata_s        = (st_data & data_mask_s) << {off_s, 3'b000};
        byteen_s       = be_mask_s << off_s;
        // Doubleword stores are meaningless on a bus narrower than 64 bits.
        misal_s        = (|(off_s & low_mask_s)) | ((st_size == 2'd3) && (B < 8));
    end

    // Handshake qualification on both sides of the FIFO.
    always_comb begin
        mem_valid_s = (count_q != {CW{1'b0}});
        st_ready    = (count_q != CW'(DEPTH));
        deq_s       = mem_valid_s & mem_ready;
        take_s      = st_valid & st_ready & ~Req & ~misal_s;
        alloc_s     = take_s & ~merge_s;
    end

`ifdef STORE_MERGE_EN
    logic [PW-1:0] young_s;

    function automatic logic [DATA_W-1:0] lanes_to_bits(input logic [B-1:0] be);
        logic [DATA_W-1:0] bits;
        for (int i = 0; i < B; i++) begin
            bits[8*i +: 8] = {8{be[i]}};
        end
        return bits;
    endfunction

    // Coalesce into the youngest entry unless it is the head leaving this cycle.
    always_comb begin
        young_s = tail_q - PW'(1);
        if (take_s && ((count_q >= CW'(2)) || ((count_q == CW'(1)) && !deq_s)) &&
            (addr_q[young_s] == aligned_addr_s)) begin
            merge_s = 1'b1;
        end else begin
            merge_s = 1'b0;
        end
    end
`else
    assign merge_s = 1'b0;
`endif

    // FIFO storage, pointers, occupancy and the one-cycle misalignment pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= {ADDR_W{1'b0}};
                data_q[i] <= {DATA_W{1'b0}};
                be_q[i]   <= {B{1'b0}};
            end
            head_q     <= {PW{1'b0}};
            tail_q     <= {PW{1'b0}};
            count_q    <= {CW{1'b0}};
            misalign_q <= 1'b0;
        end else begin
            if (alloc_s) begin
                addr_q[tail_q] <= aligned_addr_s;
                data_q[tail_q] <= wdata_s;
                be_q[tail_q]   <= byteen_s;
                tail_q         <= tail_q + PW'(1);
            end
`ifdef STORE_MERGE_EN
            if (merge_s) begin
                data_q[young_s] <= (data_q[young_s] & ~lanes_to_bits(byteen_s)) |
                                   (wdata_s & lanes_to_bits(byteen_s));
                be_q[young_s]   <= be_q[young_s] | byteen_s;
            end
`endif
            if (deq_s) begin
                head_q <= head_q + PW'(1);
            end
            case ({alloc_s, deq_s})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            misalign_q <= st_valid & ~Req & misal_s;
        end
    end

    // Present the head entry; an idle bus reads as zero.
    always_comb begin
        if (mem_valid_s) begin
            mem_addr   = addr_q[head_q];
            mem_wdata  = data_q[head_q];
            mem_byteen = be_q[head_q];
        end else begin
            mem_addr   = {ADDR_W{1'b0}};
            mem_wdata  = {DATA_W{1'b0}};
            mem_byteen = {B{1'b0}};
        end
    end

    assign mem_valid   = mem_valid_s;
    assign st_misalign = misalign_q;
    assign count       = count_q;

endmodule

// File: tb/tb_store_lane_buffer.sv
// Bench for store_lane_buffer: a 32-bit instance checked every cycle against a queue model,
// plus a 64-bit instance for doubleword and (with STORE_MERGE_EN) merge cases.
module tb_store_lane_buffer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid, Req, mem_ready;
    logic [31:0] st_addr, st_data;
    logic [1:0]  st_size;
    logic        st_ready, st_misalign, mem_valid;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_byteen;
    logic [2:0]  count;

    logic        st_valid64, Req64, mem_ready64;
    logic [31:0] st_addr64;
    logic [63:0] st_data64;
    logic [1:0]  st_size64;
    logic        st_ready64, st_misalign64, mem_valid64;
    logic [31:0] mem_addr64;
    logic [63:0] mem_wdata64;
    logic [7:0]  mem_byteen64;
    logic [2:0]  count64;

    always #5 clk = ~clk;

    store_lane_buffer #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
        .st_size(st_size), .Req(Req), .st_ready(st_ready), .st_misalign(st_misalign),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_byteen(mem_byteen), .mem_ready(mem_ready), .count(count));

    store_lane_buffer #(.DATA_W(64), .ADDR_W(32), .DEPTH(DEPTH)) dut64 (
        .clk(clk), .reset(reset), .st_valid(st_valid64), .st_addr(st_addr64), .st_data(st_data64),
        .st_size(st_size64), .Req(Req64), .st_ready(st_ready64), .st_misalign(st_misalign64),
        .mem_valid(mem_valid64), .mem_addr(mem_addr64), .mem_wdata(mem_wdata64),
        .mem_byteen(mem_byteen64), .mem_ready(mem_ready64), .count(count64));

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } entry_t;

    entry_t mq[$];
    logic   exp_mis = 1'b0;
    int     checks = 0;
    int     errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: apply the store/drain rules to the queue for one clock edge.
    task automatic model_edge();
        int          n, off, sz;
        bit          deq, rdy, mis, enq, mrg;
        logic [63:0] wd;
        logic [7:0]  be;
        entry_t      e;
        sz  = mq.size();
        deq = (sz != 0) && mem_ready;
        rdy = sz < DEPTH;
        n   = 1 << st_size;
        off = int'(st_addr % 4);
        mis = (st_size == 2'd3) || ((off % n) != 0);
        enq = st_valid && rdy && !Req && !mis;
        wd  = ((64'(st_data) & ((64'd1 << (8 * n)) - 64'd1)) << (8 * off));
        be  = ((8'd1 << n) - 8'd1) << off;
        exp_mis = st_valid && !Req && mis;
        mrg = 1'b0;
`ifdef STORE_MERGE_EN
        if (enq && sz > 0 && (sz >= 2 || !deq) && mq[sz-1].addr == {st_addr[31:2], 2'b00})
            mrg = 1'b1;
`endif
        if (deq) void'(mq.pop_front());
        if (enq) begin
            if (mrg) begin
                e = mq[mq.size()-1];
                for (int b = 0; b < 4; b++)
                    if (be[b]) e.data[8*b +: 8] = wd[8*b +: 8];
                e.be = e.be | be[3:0];
                mq[mq.size()-1] = e;
            end else begin
                e.addr = {st_addr[31:2], 2'b00};
                e.data = wd[31:0];
                e.be   = be[3:0];
                mq.push_back(e);
            end
        end
    endtask

    task automatic compare_all();
        entry_t h;
        h.addr = 32'h0; h.data = 32'h0; h.be = 4'h0;
        if (mq.size() != 0) h = mq[0];
        check("count", 64'(count), 64'(mq.size()));
        check("st_ready", 64'(st_ready), 64'(mq.size() < DEPTH));
        check("mem_valid", 64'(mem_valid), 64'(mq.size() != 0));
        check("mem_addr", 64'(mem_addr), 64'(h.addr));
        check("mem_wdata", 64'(mem_wdata), 64'(h.data));
        check("mem_byteen", 64'(mem_byteen), 64'(h.be));
        check("st_misalign", 64'(st_misalign), 64'(exp_mis));
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] s, input logic r, input logic mr);
        @(negedge clk);
        reset = 1'b1;
        st_valid = v; st_addr = a; st_data = d; st_size = s; Req = r; mem_ready = mr;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) begin
            mq.delete();
            exp_mis = 1'b0;
        end else begin
            model_edge();
        end
        #1;
        compare_all();
    endtask

    initial begin
        int thr;
        reset = 1'b0;
        st_valid = 1'b0; st_addr = 32'h0; st_data = 32'h0; st_size = 2'd0; Req = 1'b0; mem_ready = 1'b0;
        st_valid64 = 1'b0; st_addr64 = 32'h0; st_data64 = 64'h0; st_size64 = 2'd0; Req64 = 1'b0;
        mem_ready64 = 1'b1;
        #2;
        check("rst_count", 64'(count), 64'd0);
        check("rst_valid", 64'(mem_valid), 64'd0);
        check("rst_misalign", 64'(st_misalign), 64'd0);
        check("rst_addr", 64'(mem_addr), 64'd0);
        check("rst_valid64", 64'(mem_valid64), 64'd0);
        tick();

        // Byte store into the top lane.
        drive(1'b1, 32'h13, 32'hAB, 2'd0, 1'b0, 1'b1); tick();
        check("sb_addr", 64'(mem_addr), 64'h10);
        check("sb_wdata", 64'(mem_wdata), 64'hAB00_0000);
        check("sb_be", 64'(mem_byteen), 64'b1000);
        drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1); tick();
        check("sb_drained", 64'(count), 64'd0);

        // Aligned and misaligned halfwords.
        drive(1'b1, 32'h06, 32'h1234, 2'd1, 1'b0, 1'b1); tick();
        check("sh_wdata", 64'(mem_wdata), 64'h1234_0000);
        check("sh_be", 64'(mem_byteen), 64'b1100);
        drive(1'b1, 32'h05, 32'h5678, 2'd1, 1'b0, 1'b1); tick();
        check("mis_flag", 64'(st_misalign), 64'd1);
        check("mis_count", 64'(count), 64'd0);
        check("mis_valid", 64'(mem_valid), 64'd0);
        drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1); tick();
        check("mis_pulse_end", 64'(st_misalign), 64'd0);

        // Fill with memory stalled; fifth store must wait.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'(i * 4), 32'hA0 + 32'(i), 2'd2, 1'b0, 1'b0); tick();
        end
        check("full_count", 64'(count), 64'd4);
        check("full_ready", 64'(st_ready), 64'd0);
        check("full_head0", 64'(mem_addr), 64'h0);
        drive(1'b1, 32'h10, 32'hA4, 2'd2, 1'b0, 1'b1); tick();
        check("full_deq_count", 64'(count), 64'd3);
        check("full_head1", 64'(mem_addr), 64'h4);
        drive(1'b1, 32'h10, 32'hA4, 2'd2, 1'b0, 1'b1); tick();
        check("both_count", 64'(count), 64'd3);
        check("both_head2", 64'(mem_addr), 64'h8);
        drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1); tick();
        check("drain_head3", 64'(mem_addr), 64'hC);
        drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1); tick();
        check("drain_head4", 64'(mem_addr), 64'h10);
        check("drain_data4", 64'(mem_wdata), 64'hA4);
        drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1); tick();
        check("drain_empty", 64'(count), 64'd0);

        // Killed store.
        drive(1'b1, 32'h20, 32'hDEAD, 2'd2, 1'b1, 1'b1); tick();
        check("req_count", 64'(count), 64'd0);
        check("req_mis", 64'(st_misalign), 64'd0);

        // Asynchronous reset while holding three entries.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h30 + 32'(4 * i), 32'h1 + 32'(i), 2'd2, 1'b0, 1'b0); tick();
        end
        check("pre_rst_count", 64'(count), 64'd3);
        drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        check("async_rst_count", 64'(count), 64'd0);
        check("async_rst_valid", 64'(mem_valid), 64'd0);
        tick();

        // 64-bit instance: doubleword, then two bytes into one word.
        drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1);
        st_valid64 = 1'b1; st_addr64 = 32'h8; st_data64 = 64'h0123_4567_89AB_CDEF; st_size64 = 2'd3;
        mem_ready64 = 1'b1;
        tick();
        check("sd_be", 64'(mem_byteen64), 64'hFF);
        check("sd_addr", 64'(mem_addr64), 64'h8);
        check("sd_wdata", mem_wdata64, 64'h0123_4567_89AB_CDEF);
        drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1);
        st_valid64 = 1'b0;
        tick();
        check("sd_drained", 64'(count64), 64'd0);
        drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1);
        st_valid64 = 1'b1; st_addr64 = 32'h101; st_data64 = 64'h11; st_size64 = 2'd0; mem_ready64 = 1'b0;
        tick();
        drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1);
        st_addr64 = 32'h102; st_data64 = 64'h22;
        tick();
`ifdef STORE_MERGE_EN
        check("merge_count", 64'(count64), 64'd1);
        check("merge_be", 64'(mem_byteen64), 64'h06);
        check("merge_wdata", mem_wdata64, 64'h0022_1100);
`else
        check("nomerge_count", 64'(count64), 64'd2);
        check("nomerge_be", 64'(mem_byteen64), 64'h02);
        check("nomerge_wdata", mem_wdata64, 64'h1100);
`endif
        check("sb64_addr", 64'(mem_addr64), 64'h100);
        drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1);
        st_valid64 = 1'b0; mem_ready64 = 1'b1;
        tick();
        drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1); tick();
        check("sb64_drained", 64'(count64), 64'd0);

        // Randomized traffic with varying memory back-pressure and occasional reset.
        for (int i = 0; i < 600; i++) begin
            thr = ((i / 150) % 2 == 0) ? 25 : 75;
            drive($urandom_range(0, 3) != 0, 32'($urandom_range(0, 31)), $urandom,
                  2'($urandom_range(0, 3)), $urandom_range(0, 7) == 0,
                  $urandom_range(0, 99) < thr);
            if ($urandom_range(0, 149) == 0) reset = 1'b0;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/store_lane_buffer.md
Name: store_lane_buffer

Overview:
- Parametrised store path between the MEM stage and data memory/bridge.
- Steers store data onto byte lanes and generates per-byte write enables for byte, half, word and (if wide enough) doubleword stores.
- Flags misaligned stores and buffers accepted stores in a DEPTH-entry FIFO, draining them over a valid/ready memory handshake so memory stalls do not freeze the pipeline until the buffer is full.
- Req (interrupt/exception request) suppresses the incoming store.

Parameters:
- DATA_W, 32, data bus width in bits; power of two, >= 32.
- ADDR_W, 32, byte address width.
- DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- st_valid  input  1  MEM-stage store request
- st_addr  input  ADDR_W  byte address of the store
- st_data  input  DATA_W  store data, right-justified
- st_size  input  2  0=byte, 1=half, 2=word, 3=doubleword (legal only if DATA_W>=64)
- Req  input  1  exception/interrupt request; kills the store in the same cycle
- st_ready  output  1  buffer can accept a store this cycle
- st_misalign  output  1  registered store-address-error flag
- mem_valid  output  1  head entry presented to memory
- mem_addr  output  ADDR_W  head address, low log2(DATA_W/8) bits forced to 0
- mem_wdata  output  DATA_W  lane-steered head data
- mem_byteen  output  DATA_W/8  head byte enables
- mem_ready  input  1  memory accepts head this cycle
- count  output  log2(DEPTH)+1  occupied entries

Behaviour:
- Reset (reset=0, async): pointers=0, count=0, st_misalign=0, mem_valid=0, mem_addr/mem_wdata/mem_byteen=0. Reset mid-drain discards all entries; no partial write is required to complete.
- Let B=DATA_W/8, L=log2(B), off=st_addr[L-1:0], n=2^st_size bytes.
- Misaligned: off mod n != 0, or st_size=3 with DATA_W=32.
- Enqueue condition: st_valid & st_ready & !Req & !misaligned.
- Killed store (Req=1): not enqueued, st_misalign not raised.
- Lane steering: wdata = st_data[8n-1:0] << (8*off), other bits 0. byteen = ((1<<n)-1) << off. Byte: byteen=1<<off. Half: 2'b11<<off. Word in 64-bit: 4'hF<<off.
- st_misalign: registered; goes 1 the cycle after st_valid & !Req & misaligned, and is 1 for exactly one cycle per offending request. The misaligned store is never enqueued.
- st_ready = (count != DEPTH). No full-bypass: a store arriving when full with a simultaneous dequeue still sees st_ready=0.
- Latency: a store accepted at edge N appears on mem_* after edge N when the buffer was empty. There is no combinational path from st_* to mem_*.
- mem_valid = (count != 0). mem_* hold the head entry and stay stable while mem_valid & !mem_ready.
- Dequeue on mem_valid & mem_ready; head pointer advances.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. count saturates neither way; enqueue when full and dequeue when empty are impossible by construction.
- Stores drain in program order.

Optional Feature:
- Macro: STORE_MERGE_EN.
- Defined: a store that qualifies for enqueue merges into the youngest entry when all of the following hold:
  - count >= 2, or count == 1 and that entry is not dequeued this cycle;
  - the aligned address matches;
  - the youngest entry is not the head being accepted this cycle.
- Merge result: new byteen lanes overwrite data, byteen = old | new. count and tail are unchanged.
- Not defined: every qualifying store allocates a new entry; no address comparator is synthesised.

Test Plan:
- DATA_W=32, sb addr 0x13 data 0xAB, mem_ready=1 -> next cycle mem_valid=1, mem_addr=0x10, mem_wdata=0xAB000000, mem_byteen=4'b1000; one cycle later count=0.
- sh addr 0x06 data 0x1234 -> mem_wdata=0x12340000, mem_byteen=4'b1100. sh addr 0x05 -> st_misalign=1 for one cycle, count stays 0, no mem_valid.
- mem_ready=0, five sw to 0x0,0x4,0x8,0xC,0x10 -> st_ready=0 after four, count=4, fifth held. Raise mem_ready -> writes emitted in order 0x0,0x4,0x8,0xC, then the 0x10 store enters.
- Full buffer with st_valid and mem_ready both 1 for one cycle -> one dequeue, no enqueue, count=3. Next cycle enqueue+dequeue -> count stays 3, pointers wrap past DEPTH-1.
- Req=1 with sw 0x20 -> not enqueued, st_misalign=0. Assert reset low mid-drain with count=3 -> immediately count=0, mem_valid=0.
- DATA_W=64, sd addr 0x8 -> byteen=8'hFF. STORE_MERGE_EN with mem_ready=0, sb 0x101=0x11 then sb 0x102=0x22 -> single entry, byteen=8'h06, wdata[23:8]=0x2211.
